// File: rtl/spi_defines.sv
// Shared constants and types for the SPI serial data engine.
package spi_defines;

  localparam int SPI_MAX_CHAR      = 32;
  localparam int SPI_CHAR_LEN_BITS = 5;
  localparam int SPI_CNT_W         = 6;

  // A len field of zero stands for a full-width transfer.
  localparam logic [SPI_CNT_W-1:0] SPI_LEN_ZERO_DECODE = 6'd32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_bit_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
module spi_bit_cnt
  import spi_defines::*;
#(
  parameter int W = SPI_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: load wins over decrement, decrement stops at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign zero = (cnt_r == '0);

endmodule

// File: rtl/spi_shift_core.sv
// SPI master serial data engine: shifts the TX buffer out on MOSI and
// assembles MISO into rx_data, paced by the clock generator's edge strobes.
// Optional feature macro: SPI_SHIFT_LOOPBACK_EN adds a loop_en input that
// routes s_mosi back into the receive path.
module spi_shift_core
  import spi_defines::*;
#(
  parameter int MAX_CHAR      = SPI_MAX_CHAR,
  parameter int CHAR_LEN_BITS = SPI_CHAR_LEN_BITS
) (
  input  logic                     wb_clk_in,
  input  logic                     wb_rst_n,
  input  logic                     go,
  input  logic [CHAR_LEN_BITS-1:0] len,
  input  logic                     lsb,
  input  logic                     tx_negedge,
  input  logic                     rx_negedge,
  input  logic                     cpol_0,
  input  logic                     cpol_1,
  input  logic                     tx_load,
  input  logic [MAX_CHAR-1:0]      tx_data,
  input  logic                     s_miso,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic                     loop_en,
`endif
  output logic                     s_mosi,
  output logic [MAX_CHAR-1:0]      rx_data,
  output logic                     tip,
  output logic                     last_clk,
  output logic                     done
);

  localparam int CNT_W = $clog2(MAX_CHAR) + 1;
  localparam int IDX_W = $clog2(MAX_CHAR);

  spi_state_t          state_r;
  logic                tip_r;
  logic                done_r;
  logic                s_mosi_r;
  logic [MAX_CHAR-1:0] rx_data_r;
  logic [MAX_CHAR-1:0] tx_buf_r;
  logic [CNT_W-1:0]    len_lat_r;
  logic                lsb_lat_r;

  logic [CNT_W-1:0]    tx_cnt_s;
  logic [CNT_W-1:0]    rx_cnt_s;
  logic                tx_zero_s;
  logic                rx_zero_s;
  logic [CNT_W-1:0]    len_eff_s;
  logic                start_s;
  logic                tx_edge_s;
  logic                rx_edge_s;
  logic                tx_fire_s;
  logic                rx_fire_s;
  logic [CNT_W-1:0]    tx_idx_full_s;
  logic [CNT_W-1:0]    rx_idx_full_s;
  logic [IDX_W-1:0]    tx_idx_s;
  logic [IDX_W-1:0]    rx_idx_s;
  logic                rx_src_s;

  // Edge selection, counter guards and bit-index arithmetic.
  always_comb begin
    len_eff_s = (len == '0) ? CNT_W'(MAX_CHAR) : CNT_W'(len);
    start_s   = (state_r == ST_IDLE) && go;
    tx_edge_s = tip_r && (tx_negedge ? cpol_1 : cpol_0);
    rx_edge_s = tip_r && (rx_negedge ? cpol_1 : cpol_0);
    tx_fire_s = tx_edge_s && !tx_zero_s;
    // A bit may only be captured once it has been driven; compare against
    // the pre-update tx count so simultaneous strobes behave consistently.
    rx_fire_s = rx_edge_s && !rx_zero_s && (rx_cnt_s > tx_cnt_s);
    if (lsb_lat_r) begin
      tx_idx_full_s = len_lat_r - tx_cnt_s;
      rx_idx_full_s = len_lat_r - rx_cnt_s;
    end else begin
      tx_idx_full_s = tx_cnt_s - CNT_W'(1);
      rx_idx_full_s = rx_cnt_s - CNT_W'(1);
    end
    tx_idx_s = tx_idx_full_s[IDX_W-1:0];
    rx_idx_s = rx_idx_full_s[IDX_W-1:0];
`ifdef SPI_SHIFT_LOOPBACK_EN
    rx_src_s = loop_en ? s_mosi_r : s_miso;
`else
    rx_src_s = s_miso;
`endif
  end

  spi_bit_cnt #(.W(CNT_W)) u_tx_cnt (
    .clk      (wb_clk_in),
    .rst_n    (wb_rst_n),
    .load     (start_s),
    .load_val (len_eff_s),
    .dec      (tx_fire_s),
    .cnt      (tx_cnt_s),
    .zero     (tx_zero_s)
  );

  spi_bit_cnt #(.W(CNT_W)) u_rx_cnt (
    .clk      (wb_clk_in),
    .rst_n    (wb_rst_n),
    .load     (start_s),
    .load_val (len_eff_s),
    .dec      (rx_fire_s),
    .cnt      (rx_cnt_s),
    .zero     (rx_zero_s)
  );

  // Transfer FSM with registered serial/parallel outputs and TX buffer.
  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_n) begin
      state_r   <= ST_IDLE;
      tip_r     <= 1'b0;
      done_r    <= 1'b0;
      s_mosi_r  <= 1'b0;
      rx_data_r <= '0;
      tx_buf_r  <= '0;
      len_lat_r <= '0;
      lsb_lat_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Buffer is writable only while idle; a same-cycle go shifts
          // this new word since shifting begins on a later strobe.
          if (tx_load) begin
            tx_buf_r <= tx_data;
          end
          if (go) begin
            state_r   <= ST_RUN;
            tip_r     <= 1'b1;
            len_lat_r <= len_eff_s;
            lsb_lat_r <= lsb;
          end
        end
        ST_RUN: begin
          if (tx_fire_s) begin
            s_mosi_r <= tx_buf_r[tx_idx_s];
          end
          if (rx_fire_s) begin
            rx_data_r[rx_idx_s] <= rx_src_s;
          end
          if (rx_zero_s) begin
            state_r <= ST_IDLE;
            tip_r   <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tip_r   <= 1'b0;
        end
      endcase
    end
  end

  assign s_mosi   = s_mosi_r;
  assign rx_data  = rx_data_r;
  assign tip      = tip_r;
  assign done     = done_r;
  assign last_clk = tip_r && tx_zero_s;

endmodule

// File: tb/tb_spi_shift_core.sv
// Directed self-checking bench for spi_shift_core (MOSI looped to MISO).
module tb_spi_shift_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic [4:0]  len;
  logic        lsb;
  logic        tx_negedge;
  logic        rx_negedge;
  logic        cpol_0;
  logic        cpol_1;
  logic        tx_load;
  logic [31:0] tx_data;
  logic        s_miso;
  logic        s_mosi;
  logic [31:0] rx_data;
  logic        tip;
  logic        last_clk;
  logic        done;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign s_miso = s_mosi;

  spi_shift_core dut (
    .wb_clk_in  (clk),
    .wb_rst_n   (rst_n),
    .go         (go),
    .len        (len),
    .lsb        (lsb),
    .tx_negedge (tx_negedge),
    .rx_negedge (rx_negedge),
    .cpol_0     (cpol_0),
    .cpol_1     (cpol_1),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .s_miso     (s_miso),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loop_en    (1'b0),
`endif
    .s_mosi     (s_mosi),
    .rx_data    (rx_data),
    .tip        (tip),
    .last_clk   (last_clk),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tx();
    cpol_1 = 1'b1;
    tick();
    cpol_1 = 1'b0;
  endtask

  task automatic pulse_rx();
    cpol_0 = 1'b1;
    tick();
    cpol_0 = 1'b0;
  endtask

  // Load the buffer and start in the same idle cycle.
  task automatic load_go(input logic [31:0] data, input logic [4:0] l, input logic lsb_v);
    tx_data = data;
    tx_load = 1'b1;
    len     = l;
    lsb     = lsb_v;
    go      = 1'b1;
    tick();
    tx_load = 1'b0;
    go      = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_mosi"}, 32'(s_mosi), 32'd0);
    check({tag, "_rx"}, rx_data, 32'd0);
    check({tag, "_tip"}, 32'(tip), 32'd0);
    check({tag, "_last"}, 32'(last_clk), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  logic [31:0] w;
  logic [31:0] exp_bit;

  initial begin
    rst_n = 1'b0; go = 1'b0; len = 5'd0; lsb = 1'b0;
    tx_negedge = 1'b1; rx_negedge = 1'b0;
    cpol_0 = 1'b0; cpol_1 = 1'b0; tx_load = 1'b0; tx_data = 32'd0;
    repeat (3) tick();
    check_idle_zero("rst_init");
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a transfer.
    load_go(32'h0000_00FF, 5'd8, 1'b0);
    check("rst_tip_up", 32'(tip), 32'd1);
    pulse_tx(); pulse_rx(); pulse_tx(); pulse_rx();
    check("rst_pre_rx", rx_data, 32'h0000_00C0);
    rst_n = 1'b0;
    repeat (3) tick();
    check_idle_zero("rst_mid");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse_tx();
      pulse_rx();
      check("rst_no_done", 32'(done), 32'd0);
      check("rst_no_mosi", 32'(s_mosi), 32'd0);
    end
    check("rst_tip_low", 32'(tip), 32'd0);

    // MSB-first, 8 bits of 0xA5.
    load_go(32'h0000_00A5, 5'd8, 1'b0);
    check("msb_tip", 32'(tip), 32'd1);
    check("msb_last0", 32'(last_clk), 32'd0);
    w = 32'h0000_00A5;
    for (int i = 0; i < 8; i++) begin
      pulse_tx();
      exp_bit = (w >> (7 - i)) & 32'd1;
      check("msb_mosi", 32'(s_mosi), exp_bit);
      check("msb_last", 32'(last_clk), (i == 7) ? 32'd1 : 32'd0);
      pulse_rx();
    end
    check("msb_done_early", 32'(done), 32'd0);
    tick();
    check("msb_done", 32'(done), 32'd1);
    check("msb_tip_fall", 32'(tip), 32'd0);
    check("msb_rx", rx_data, 32'h0000_00A5);
    tick();
    check("msb_done_once", 32'(done), 32'd0);

    // LSB-first, full 32-bit length.
    load_go(32'h8000_0001, 5'd0, 1'b1);
    w = 32'h8000_0001;
    for (int i = 0; i < 32; i++) begin
      pulse_tx();
      exp_bit = (w >> i) & 32'd1;
      check("lsb_mosi", 32'(s_mosi), exp_bit);
      if (i == 30) check("lsb_last_pre", 32'(last_clk), 32'd0);
      if (i == 31) check("lsb_last", 32'(last_clk), 32'd1);
      pulse_rx();
    end
    tick();
    check("lsb_done", 32'(done), 32'd1);
    check("lsb_rx", rx_data, 32'h8000_0001);
    tick();

    // Single bit; rx_data bits above bit 0 must be preserved.
    load_go(32'h0000_0001, 5'd1, 1'b0);
    check("one_last0", 32'(last_clk), 32'd0);
    pulse_tx();
    check("one_last", 32'(last_clk), 32'd1);
    check("one_mosi", 32'(s_mosi), 32'd1);
    pulse_rx();
    check("one_done_early", 32'(done), 32'd0);
    tick();
    check("one_done", 32'(done), 32'd1);
    check("one_rx", rx_data, 32'h8000_0001);
    tick();

    // Protection: go and tx_load mid-transfer must be ignored.
    load_go(32'h0000_0005, 5'd4, 1'b0);
    pulse_tx();
    check("prot_b0", 32'(s_mosi), 32'd0);
    pulse_rx();
    tx_data = 32'h0000_00FF; tx_load = 1'b1; go = 1'b1; len = 5'd8;
    tick();
    tx_load = 1'b0; go = 1'b0;
    w = 32'h0000_0005;
    for (int i = 1; i < 4; i++) begin
      pulse_tx();
      exp_bit = (w >> (3 - i)) & 32'd1;
      check("prot_mosi", 32'(s_mosi), exp_bit);
      pulse_rx();
    end
    check("prot_last", 32'(last_clk), 32'd1);
    tick();
    check("prot_done", 32'(done), 32'd1);
    check("prot_rx", rx_data, 32'h8000_0005);
    tick();

    // Rx guard: rx strobe before any tx strobe does nothing.
    load_go(32'h0000_0003, 5'd2, 1'b0);
    pulse_rx();
    check("guard_rx", rx_data, 32'h8000_0005);
    check("guard_done", 32'(done), 32'd0);
    pulse_tx(); pulse_rx();
    pulse_tx(); pulse_rx();
    check("guard_not_done_yet", 32'(done), 32'd0);
    tick();
    check("guard_done_end", 32'(done), 32'd1);
    check("guard_rx_end", rx_data, 32'h8000_0007);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
